// File: rtl/flow_stat_pkg.sv
// Shared constants for the flow statistics monitor: register addresses,
// control FSM encoding and bit offsets of the metadata/control fields.
package flow_stat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FWD2  = 3'd1,
    ST_RESP2 = 3'd2,
    ST_DROP2 = 3'd3
  } ctl_state_t;

  localparam logic [31:0] ADDR_STATE = 32'h7000_0000;
  localparam logic [31:0] ADDR_CLR   = 32'h7000_0001;
  localparam logic [31:0] ADDR_CFG   = 32'h7000_0010;
  localparam logic [31:0] ADDR_CNT   = 32'h7000_0100;
  localparam logic [31:0] ADDR_LAT   = 32'h7000_0200;

  localparam int HDR_LSB  = 132;
  localparam int OP_LSB   = 124;
  localparam int SRC_LSB  = 104;
  localparam int DST_LSB  = 96;
  localparam int ADDR_LSB = 64;

  localparam int MD_LEN_LSB   = 96;
  localparam int MD_ID_LSB    = 80;
  localparam int MD_PROTO_LSB = 72;
  localparam int PHV_TS_LSB   = 544;

  localparam logic [1:0] HDR_FIRST  = 2'b01;
  localparam logic [1:0] HDR_SECOND = 2'b10;
  localparam logic [2:0] OP_WR      = 3'b010;
  localparam logic [2:0] OP_RD      = 3'b001;
  localparam logic [3:0] RESP_TAG   = 4'b1011;

endpackage

// File: rtl/flow_stat_chan.sv
// One statistics channel: enable/protocol match, byte and packet counters,
// and maximum observed latency. Clear has priority over writes and counts.
module flow_stat_chan
  import flow_stat_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hit,
  input  logic [7:0]  i_proto,
  input  logic [11:0] i_len,
  input  logic [31:0] i_lat,
  input  logic        i_clr,
  input  logic        i_cfg_we,
  input  logic [3:0]  i_cnt_we,
  input  logic [31:0] i_wdata,
  output logic [8:0]  o_cfg,
  output logic [63:0] o_bytes,
  output logic [63:0] o_pkts,
  output logic [31:0] o_maxlat
);

  logic             r_en;
  logic [7:0]       r_proto;
  logic [CNT_W-1:0] r_bytes;
  logic [CNT_W-1:0] r_pkts;
  logic [31:0]      r_maxlat;
  logic             w_cnt;

  assign w_cnt    = i_hit && r_en && (i_proto == r_proto);
  assign o_cfg    = {r_en, r_proto};
  assign o_bytes  = 64'(r_bytes);
  assign o_pkts   = 64'(r_pkts);
  assign o_maxlat = r_maxlat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_proto <= '0;
    end else if (i_cfg_we) begin
      {r_en, r_proto} <= i_wdata[8:0];
    end
  end

  // Counter words are writable so software can preload them; i_cnt_we is
  // {pkts hi, pkts lo, bytes hi, bytes lo}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bytes  <= '0;
      r_pkts   <= '0;
      r_maxlat <= '0;
    end else if (i_clr) begin
      r_bytes  <= '0;
      r_pkts   <= '0;
      r_maxlat <= '0;
    end else begin
      if (i_cnt_we[0])      r_bytes <= {r_bytes[CNT_W-1:32], i_wdata};
      else if (i_cnt_we[1]) r_bytes <= {i_wdata[CNT_W-33:0], r_bytes[31:0]};
      else if (w_cnt)       r_bytes <= r_bytes + {{(CNT_W-12){1'b0}}, i_len};

      if (i_cnt_we[2])      r_pkts <= {r_pkts[CNT_W-1:32], i_wdata};
      else if (i_cnt_we[3]) r_pkts <= {i_wdata[CNT_W-33:0], r_pkts[31:0]};
      else if (w_cnt)       r_pkts <= r_pkts + {{(CNT_W-1){1'b0}}, 1'b1};

      if (w_cnt && (i_lat > r_maxlat)) r_maxlat <= i_lat;
    end
  end

endmodule

// File: rtl/flow_stat_mon.sv
// Flow statistics monitor: 1-cycle pass-through data path with per-protocol
// byte/packet/latency counters exposed over a two-beat control channel.
module flow_stat_mon
  import flow_stat_pkg::*;
#(
  parameter logic [7:0] LMID  = 8'd7,
  parameter logic [7:0] NMID  = 8'd4,
  parameter int         NCH   = 4,
  parameter int         CNT_W = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [255:0]  in_md,
  input  logic          in_md_wr,
  input  logic [1023:0] in_phv,
  input  logic          in_phv_wr,
  output logic          out_md_alf,
  output logic          out_phv_alf,
  output logic [255:0]  out_md,
  output logic          out_md_wr,
  output logic [1023:0] out_phv,
  output logic          out_phv_wr,
  input  logic          in_md_alf,
  input  logic          in_phv_alf,
  input  logic          sent_start,
  input  logic [31:0]   timestamp,
  input  logic [133:0]  cin_data,
  input  logic          cin_data_wr,
  output logic          cout_ready,
  output logic [133:0]  cout_data,
  output logic          cout_data_wr,
  input  logic          cin_ready
);

  logic        w_accept, w_local, w_hit;
  logic [31:0] w_lat;

  assign out_md_alf  = in_md_alf;
  assign out_phv_alf = in_phv_alf;
  assign cout_ready  = cin_ready;

  assign w_accept = in_md_wr & in_phv_wr;
  assign w_local  = (in_md[MD_ID_LSB +: 8] == LMID);
  assign w_hit    = w_accept & w_local & sent_start;
  assign w_lat    = timestamp - in_phv[PHV_TS_LSB +: 32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_md     <= '0;
      out_md_wr  <= 1'b0;
      out_phv    <= '0;
      out_phv_wr <= 1'b0;
    end else begin
      out_md_wr  <= w_accept;
      out_phv_wr <= w_accept;
      out_md     <= '0;
      out_phv    <= '0;
      if (w_accept) begin
        out_md  <= w_local ? {in_md[255:88], NMID, in_md[79:0]} : in_md;
        out_phv <= in_phv;
      end
    end
  end

  ctl_state_t  r_state, w_state_next;
  logic [1:0]  w_hdr;
  logic [2:0]  w_op;
  logic [7:0]  w_src, w_dst;
  logic [31:0] w_addr, w_wdata, w_rdata;
  logic        w_loc_ctl, w_wr, w_rd, w_emit;
  logic [133:0] w_emit_data;

  assign w_hdr   = cin_data[HDR_LSB +: 2];
  assign w_op    = cin_data[OP_LSB +: 3];
  assign w_src   = cin_data[SRC_LSB +: 8];
  assign w_dst   = cin_data[DST_LSB +: 8];
  assign w_addr  = cin_data[ADDR_LSB +: 32];
  assign w_wdata = cin_data[31:0];

  assign w_loc_ctl = cin_data_wr && (r_state == ST_IDLE) && (w_hdr == HDR_FIRST) && (w_dst == LMID);
  assign w_wr      = w_loc_ctl && (w_op == OP_WR);
  assign w_rd      = w_loc_ctl && (w_op == OP_RD);

  logic [8:0]  w_cfg     [NCH];
  logic [63:0] w_bytes   [NCH];
  logic [63:0] w_pkts    [NCH];
  logic [31:0] w_maxlat  [NCH];
  logic [31:0] w_shd_b   [NCH];
  logic [31:0] w_shd_p   [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic        w_clr, w_cfg_we;
    logic [3:0]  w_cnt_we;
    logic [31:0] r_shd_b, r_shd_p;

    assign w_clr    = w_wr && (w_addr == ADDR_CLR) && w_wdata[gi];
    assign w_cfg_we = w_wr && (w_addr == ADDR_CFG + 32'(gi));
    assign w_cnt_we = {w_wr && (w_addr == ADDR_CNT + 32'(4*gi+3)),
                       w_wr && (w_addr == ADDR_CNT + 32'(4*gi+2)),
                       w_wr && (w_addr == ADDR_CNT + 32'(4*gi+1)),
                       w_wr && (w_addr == ADDR_CNT + 32'(4*gi))};

    // A lo read snapshots the hi half so the following hi read is coherent.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shd_b <= '0;
        r_shd_p <= '0;
      end else if (w_rd) begin
        if (w_addr == ADDR_CNT + 32'(4*gi))   r_shd_b <= w_bytes[gi][63:32];
        if (w_addr == ADDR_CNT + 32'(4*gi+2)) r_shd_p <= w_pkts[gi][63:32];
      end
    end
    assign w_shd_b[gi] = r_shd_b;
    assign w_shd_p[gi] = r_shd_p;

    flow_stat_chan #(.CNT_W(CNT_W)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_hit    (w_hit),
      .i_proto  (in_md[MD_PROTO_LSB +: 8]),
      .i_len    (in_md[MD_LEN_LSB +: 12]),
      .i_lat    (w_lat),
      .i_clr    (w_clr),
      .i_cfg_we (w_cfg_we),
      .i_cnt_we (w_cnt_we),
      .i_wdata  (w_wdata),
      .o_cfg    (w_cfg[gi]),
      .o_bytes  (w_bytes[gi]),
      .o_pkts   (w_pkts[gi]),
      .o_maxlat (w_maxlat[gi])
    );
  end

  always_comb begin
    w_rdata = 32'hFFFF_FFFF;
    if (w_addr == ADDR_STATE) w_rdata = {29'b0, r_state};
    for (int k = 0; k < NCH; k++) begin
      if (w_addr == ADDR_CFG + 32'(k))     w_rdata = {23'b0, w_cfg[k]};
      if (w_addr == ADDR_CNT + 32'(4*k))   w_rdata = w_bytes[k][31:0];
      if (w_addr == ADDR_CNT + 32'(4*k+1)) w_rdata = w_shd_b[k];
      if (w_addr == ADDR_CNT + 32'(4*k+2)) w_rdata = w_pkts[k][31:0];
      if (w_addr == ADDR_CNT + 32'(4*k+3)) w_rdata = w_shd_p[k];
      if (w_addr == ADDR_LAT + 32'(k))     w_rdata = w_maxlat[k];
    end
  end

  // Any beat outside the expected sequence is forwarded and the FSM resyncs.
  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    w_emit_data  = cin_data;
    if (cin_data_wr) begin
      w_emit       = 1'b1;
      w_state_next = ST_IDLE;
      case (r_state)
        ST_IDLE: begin
          if (w_hdr == HDR_FIRST) begin
            if (w_wr) begin
              w_emit       = 1'b0;
              w_state_next = ST_DROP2;
            end else if (w_rd) begin
              w_emit_data  = {cin_data[133:128], RESP_TAG, cin_data[123:112],
                              w_dst, w_src, cin_data[95:32], w_rdata};
              w_state_next = ST_RESP2;
            end else begin
              w_state_next = ST_FWD2;
            end
          end
        end
        ST_DROP2: if (w_hdr == HDR_SECOND) w_emit = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      cout_data    <= '0;
      cout_data_wr <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      cout_data_wr <= w_emit;
      cout_data    <= w_emit ? w_emit_data : '0;
    end
  end

endmodule

// File: tb/tb_flow_stat_mon.sv
// Directed bench for flow_stat_mon: data path rewrite, counting, latency,
// coherent 64-bit reads, clear priority and control-channel forwarding.
module tb_flow_stat_mon;

  localparam logic [1:0] H1   = 2'b01;
  localparam logic [1:0] H2   = 2'b10;
  localparam logic [2:0] OPW  = 3'b010;
  localparam logic [2:0] OPR  = 3'b001;
  localparam logic [7:0] LOC  = 8'd7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [255:0]  in_md = '0;
  logic          in_md_wr = 1'b0;
  logic [1023:0] in_phv = '0;
  logic          in_phv_wr = 1'b0;
  logic          out_md_alf, out_phv_alf;
  logic [255:0]  out_md;
  logic          out_md_wr;
  logic [1023:0] out_phv;
  logic          out_phv_wr;
  logic          in_md_alf = 1'b0;
  logic          in_phv_alf = 1'b0;
  logic          sent_start = 1'b0;
  logic [31:0]   timestamp = '0;
  logic [133:0]  cin_data = '0;
  logic          cin_data_wr = 1'b0;
  logic          cout_ready;
  logic [133:0]  cout_data;
  logic          cout_data_wr;
  logic          cin_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  logic [255:0]  last_md;
  logic [1023:0] last_phv;
  logic [31:0]   rd;
  logic [133:0]  beat;

  always #5 clk = ~clk;

  flow_stat_mon dut (
    .clk(clk), .rst_n(rst_n),
    .in_md(in_md), .in_md_wr(in_md_wr), .in_phv(in_phv), .in_phv_wr(in_phv_wr),
    .out_md_alf(out_md_alf), .out_phv_alf(out_phv_alf),
    .out_md(out_md), .out_md_wr(out_md_wr), .out_phv(out_phv), .out_phv_wr(out_phv_wr),
    .in_md_alf(in_md_alf), .in_phv_alf(in_phv_alf),
    .sent_start(sent_start), .timestamp(timestamp),
    .cin_data(cin_data), .cin_data_wr(cin_data_wr),
    .cout_ready(cout_ready), .cout_data(cout_data), .cout_data_wr(cout_data_wr),
    .cin_ready(cin_ready)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [133:0] mk_ctl(input logic [1:0] hdr, input logic [2:0] op,
                                          input logic [7:0] src, input logic [7:0] dst,
                                          input logic [31:0] addr, input logic [31:0] data);
    logic [133:0] d;
    d = '0;
    d[133:132] = hdr;
    d[129:128] = 2'b10;
    d[126:124] = op;
    d[123:112] = 12'h5C3;
    d[111:104] = src;
    d[103:96]  = dst;
    d[95:64]   = addr;
    d[63:32]   = 32'h1234_5678;
    d[31:0]    = data;
    return d;
  endfunction

  task automatic send_ctl(input logic [133:0] d);
    @(negedge clk);
    cin_data    = d;
    cin_data_wr = 1'b1;
    @(negedge clk);
    cin_data_wr = 1'b0;
  endtask

  task automatic ctl_write(input logic [31:0] addr, input logic [31:0] data);
    logic w1;
    send_ctl(mk_ctl(H1, OPW, 8'h01, LOC, addr, data));
    w1 = cout_data_wr;
    send_ctl(mk_ctl(H2, OPW, 8'h01, LOC, addr, data));
    chk("write_silent", {w1, cout_data_wr}, 2'b00);
    $display("write %h <- %h", addr, data);
  endtask

  task automatic ctl_read(input logic [31:0] addr, output logic [31:0] r);
    send_ctl(mk_ctl(H1, OPR, 8'h01, LOC, addr, 32'h0));
    r = cout_data_wr ? cout_data[31:0] : 32'hDEAD_BEEF;
    send_ctl(mk_ctl(H2, OPR, 8'h01, LOC, addr, 32'h0));
    $display("read  %h -> %h", addr, r);
  endtask

  task automatic set_beat(input logic [7:0] id, input logic [7:0] proto, input logic [11:0] len,
                          input logic [31:0] phv_ts, input logic [31:0] ts);
    last_md            = '0;
    last_md[255:224]   = $urandom;
    last_md[107:96]    = len;
    last_md[87:80]     = id;
    last_md[79:72]     = proto;
    last_md[31:0]      = $urandom;
    last_phv           = '0;
    last_phv[1023:992] = $urandom;
    last_phv[575:544]  = phv_ts;
    last_phv[31:0]     = $urandom;
    in_md      = last_md;
    in_phv     = last_phv;
    timestamp  = ts;
    in_md_wr   = 1'b1;
    in_phv_wr  = 1'b1;
  endtask

  task automatic send_beat(input logic [7:0] id, input logic [7:0] proto, input logic [11:0] len,
                           input logic [31:0] phv_ts, input logic [31:0] ts);
    @(negedge clk);
    set_beat(id, proto, len, phv_ts, ts);
    @(negedge clk);
    in_md_wr  = 1'b0;
    in_phv_wr = 1'b0;
    $display("beat  id=%0d proto=%0h len=%0d out_id=%0d", id, proto, len, out_md[87:80]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_md_wr", {out_md_wr, out_phv_wr, cout_data_wr}, 3'b000);
    chk("rst_md", out_md, 256'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    in_md_alf = 1'b1; cin_ready = 1'b1; #1;
    chk("passthru_flags", {out_md_alf, out_phv_alf, cout_ready}, 3'b101);
    ctl_read(32'h7000_0000, rd);
    chk("state_after_reset", rd, 32'h0);

    // Channels 0 and 2 both watch protocol 6.
    ctl_write(32'h7000_0010, 32'h106);
    ctl_write(32'h7000_0012, 32'h106);
    sent_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_beat(8'd7, 8'd6, 12'd100, 32'd20, 32'd20);
      chk("local_md", out_md, {last_md[255:88], 8'd4, last_md[79:0]});
      chk("local_phv", {out_phv == last_phv, out_md_wr, out_phv_wr}, 3'b111);
    end
    send_beat(8'd9, 8'd6, 12'd100, 32'd0, 32'd0);
    chk("remote_md", out_md, last_md);
    send_beat(8'd7, 8'h2A, 12'd100, 32'd0, 32'd0);
    sent_start = 1'b0;
    send_beat(8'd7, 8'd6, 12'd100, 32'd0, 32'd0);
    sent_start = 1'b1;
    @(negedge clk);
    set_beat(8'd7, 8'd6, 12'd100, 32'd0, 32'd0);
    in_phv_wr = 1'b0;
    @(negedge clk);
    in_md_wr = 1'b0;
    chk("md_only_wr", {out_md_wr, out_phv_wr}, 2'b00);
    chk("md_only_data", out_md, 256'h0);

    ctl_read(32'h7000_0100, rd); chk("ch0_bytes_lo", rd, 32'd300);
    ctl_read(32'h7000_0101, rd); chk("ch0_bytes_hi", rd, 32'd0);
    ctl_read(32'h7000_0102, rd); chk("ch0_pkts_lo", rd, 32'd3);
    ctl_read(32'h7000_010A, rd); chk("ch2_pkts_lo", rd, 32'd3);

    send_beat(8'd7, 8'd6, 12'd100, 32'hFFFF_FFFE, 32'd5);
    ctl_read(32'h7000_0200, rd); chk("ch0_maxlat_wrap", rd, 32'd7);
    send_beat(8'd7, 8'd6, 12'd100, 32'd7, 32'd10);
    ctl_read(32'h7000_0200, rd); chk("ch0_maxlat_keep", rd, 32'd7);
    ctl_read(32'h7000_0202, rd); chk("ch2_maxlat", rd, 32'd7);

    ctl_write(32'h7000_0011, 32'h111);
    ctl_read(32'h7000_0011, rd); chk("ch1_cfg", rd, 32'h111);
    ctl_write(32'h7000_0106, 32'hFFFF_FFFF);
    send_beat(8'd7, 8'h11, 12'd1, 32'd0, 32'd0);
    ctl_read(32'h7000_0106, rd); chk("ch1_pkts_lo", rd, 32'd0);
    ctl_read(32'h7000_0107, rd); chk("ch1_pkts_hi", rd, 32'd1);
    ctl_read(32'h7000_0104, rd); chk("ch1_bytes_lo", rd, 32'd1);

    // Clear channel 0 in the same cycle that a counted beat arrives.
    @(negedge clk);
    cin_data    = mk_ctl(H1, OPW, 8'h01, LOC, 32'h7000_0001, 32'h1);
    cin_data_wr = 1'b1;
    set_beat(8'd7, 8'd6, 12'd100, 32'd0, 32'd50);
    @(negedge clk);
    in_md_wr  = 1'b0;
    in_phv_wr = 1'b0;
    chk("clr_beat_out", {out_md_wr, out_md[87:80], cout_data_wr}, {1'b1, 8'd4, 1'b0});
    cin_data = mk_ctl(H2, OPW, 8'h01, LOC, 32'h7000_0001, 32'h1);
    @(negedge clk);
    cin_data_wr = 1'b0;
    $display("clear mask 1 with concurrent beat");
    ctl_read(32'h7000_0100, rd); chk("clr_bytes_lo", rd, 32'd0);
    ctl_read(32'h7000_0101, rd); chk("clr_bytes_hi", rd, 32'd0);
    ctl_read(32'h7000_0102, rd); chk("clr_pkts_lo", rd, 32'd0);
    ctl_read(32'h7000_0103, rd); chk("clr_pkts_hi", rd, 32'd0);
    ctl_read(32'h7000_0200, rd); chk("clr_maxlat", rd, 32'd0);
    ctl_read(32'h7000_010A, rd); chk("ch2_not_cleared", rd, 32'd6);

    beat = mk_ctl(H1, OPR, 8'h01, 8'd8, 32'h7000_0000, 32'h0);
    send_ctl(beat);
    chk("fwd_beat1", {cout_data_wr, cout_data}, {1'b1, beat});
    beat = mk_ctl(H2, OPR, 8'h01, 8'd8, 32'h7000_0000, 32'h0);
    send_ctl(beat);
    chk("fwd_beat2", {cout_data_wr, cout_data}, {1'b1, beat});

    send_ctl(mk_ctl(H1, OPR, 8'h01, LOC, 32'h7000_0999, 32'h0));
    chk("unmapped_resp", {cout_data_wr, cout_data},
        {1'b1, 6'b010010, 4'b1011, 12'h5C3, 8'h07, 8'h01, 32'h7000_0999,
         32'h1234_5678, 32'hFFFF_FFFF});
    beat = mk_ctl(H2, OPR, 8'h01, LOC, 32'h7000_0999, 32'h0);
    send_ctl(beat);
    chk("resp_beat2", {cout_data_wr, cout_data}, {1'b1, beat});

    beat = mk_ctl(H2, OPR, 8'h01, LOC, 32'h7000_0000, 32'hAB);
    send_ctl(beat);
    chk("stray_second", {cout_data_wr, cout_data}, {1'b1, beat});
    send_ctl(mk_ctl(H1, OPW, 8'h01, LOC, 32'h7000_0014, 32'h1FF));
    chk("drop_first", cout_data_wr, 1'b0);
    beat = mk_ctl(H1, OPR, 8'h01, 8'd8, 32'h7000_0000, 32'h0);
    send_ctl(beat);
    chk("resync_first", {cout_data_wr, cout_data}, {1'b1, beat});
    ctl_read(32'h7000_0014, rd); chk("unmapped_write_ignored", rd, 32'hFFFF_FFFF);
    ctl_read(32'h7000_0010, rd); chk("ch0_cfg", rd, 32'h106);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
